// File: rtl/async_fifo_pkg.sv
// Shared constants for async_fifo and its read-side stream adapter, plus a pointer-width helper.
package async_fifo_pkg;

    localparam int DEFAULT_BITS      = 32;
    localparam int DEFAULT_SIZE      = 16;
    localparam int DEFAULT_BUF_DEPTH = 3;

    // Bits needed to index n entries; never less than one so 1- and 2-entry cases stay legal.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/fifo_read_stream_buf.sv
// Circular BUF_DEPTH x BITS prefetch store; head/tail wrap modulo BUF_DEPTH (any depth >= 2).
module fifo_read_stream_buf
    import async_fifo_pkg::*;
#(
    parameter int BITS      = DEFAULT_BITS,
    parameter int BUF_DEPTH = DEFAULT_BUF_DEPTH
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     push,
    input  logic [BITS-1:0]                          push_data,
    input  logic                                     pop,
    output logic [BITS-1:0]                          head_data,
    output logic [clog2_min1(BUF_DEPTH + 1)-1:0]     count
);

    localparam int PTR_W = clog2_min1(BUF_DEPTH);
    localparam int CNT_W = clog2_min1(BUF_DEPTH + 1);

    logic [BITS-1:0]  mem [BUF_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // Storage is cleared too, so the head word reads as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= next_ptr(tail);
            end
            if (pop) begin
                head <= next_ptr(head);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[head];

endmodule

// File: rtl/fifo_read_stream.sv
// Drains the async_fifo read port into a valid/ready stream; optional counters under FIFO_READ_STREAM_STATS_EN.
module fifo_read_stream
    import async_fifo_pkg::*;
#(
    parameter int BITS      = DEFAULT_BITS,
    parameter int BUF_DEPTH = DEFAULT_BUF_DEPTH
) (
    input  logic            read_clk,
    input  logic            read_rst_n,
    output logic            p_read_en,
    input  logic [BITS-1:0] p_read_data,
    input  logic            p_read_empty,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [BITS-1:0] m_data
`ifdef FIFO_READ_STREAM_STATS_EN
    ,
    output logic [31:0]     stat_beats,
    output logic [31:0]     stat_stalls
`endif
);

    localparam int CNT_W = clog2_min1(BUF_DEPTH + 1);

    logic             run;
    logic             inflight;
    logic [CNT_W-1:0] count;
    logic             pop;

    // Reserve a slot for every outstanding read so the buffer can never overflow; m_ready is not involved.
    assign p_read_en = run && !p_read_empty &&
                       (({1'b0, count} + (CNT_W + 1)'(inflight)) < (CNT_W + 1)'(BUF_DEPTH));

    assign m_valid = (count != '0);
    assign pop     = m_valid && m_ready;

    always_ff @(posedge read_clk or negedge read_rst_n) begin
        if (!read_rst_n) begin
            run      <= 1'b0;
            inflight <= 1'b0;
        end else begin
            run      <= 1'b1;
            inflight <= p_read_en;
        end
    end

    fifo_read_stream_buf #(
        .BITS      (BITS),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (read_clk),
        .rst_n     (read_rst_n),
        .push      (inflight),
        .push_data (p_read_data),
        .pop       (pop),
        .head_data (m_data),
        .count     (count)
    );

`ifdef FIFO_READ_STREAM_STATS_EN
    always_ff @(posedge read_clk or negedge read_rst_n) begin
        if (!read_rst_n) begin
            stat_beats  <= '0;
            stat_stalls <= '0;
        end else begin
            if (pop) begin
                stat_beats <= stat_beats + 32'd1;
            end
            if (m_valid && !m_ready) begin
                stat_stalls <= stat_stalls + 32'd1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    a_no_read_when_empty: assert property (@(posedge read_clk) disable iff (!read_rst_n)
        !(p_read_en && p_read_empty));
    a_count_bounded: assert property (@(posedge read_clk) disable iff (!read_rst_n)
        count <= CNT_W'(BUF_DEPTH));
    a_data_held: assert property (@(posedge read_clk) disable iff (!read_rst_n)
        (m_valid && !m_ready) |=> $stable(m_data));
`endif

endmodule

// File: tb/tb_fifo_read_stream.sv
// Scoreboard bench: a queue-based FIFO model feeds the DUT; every word written is expected back in order.
module tb_fifo_read_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p_read_en;
    logic [31:0] p_read_data = '0;
    logic        p_read_empty = 1'b1;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
`ifdef FIFO_READ_STREAM_STATS_EN
    logic [31:0] stat_beats;
    logic [31:0] stat_stalls;
`endif

    fifo_read_stream dut (
        .read_clk     (clk),
        .read_rst_n   (rst_n),
        .p_read_en    (p_read_en),
        .p_read_data  (p_read_data),
        .p_read_empty (p_read_empty),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data)
`ifdef FIFO_READ_STREAM_STATS_EN
        ,
        .stat_beats   (stat_beats),
        .stat_stalls  (stat_stalls)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] fifo_q[$];
    logic [31:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        req_s = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    int          beats = 0;
    int          stalls = 0;
    logic        wr_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic put(input logic [31:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic drv_slot();
        @(posedge clk);
        #2;
    endtask

    // Upstream FIFO model: one-cycle read latency, registered empty flag.
    always @(posedge clk) begin
        if (!rst_n) begin
            p_read_data  <= '0;
            p_read_empty <= (fifo_q.size() == 0);
        end else begin
            if (req_s) begin
                if (fifo_q.size() == 0) begin
                    check("fifo_underflow", 32'd1, 32'd0);
                end else begin
                    p_read_data <= fifo_q.pop_front();
                end
            end
            p_read_empty <= (fifo_q.size() == 0);
        end
    end

    // Monitor: samples on the falling edge, pops the scoreboard on each handshake.
    always @(negedge clk) begin
        req_s = p_read_en;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", {31'd0, m_valid}, 32'd1);
                check("hold_data", m_data, prev_data);
            end
            if (m_valid && m_ready) begin
                beats++;
                if (exp_q.size() == 0) begin
                    check("unexpected_word", m_data, 32'hxxxx_xxxx);
                end else begin
                    check("stream_data", m_data, exp_q.pop_front());
                end
            end
            if (m_valid && !m_ready) stalls++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int waited;
        int run_len;
        int pulses;
        int beats0;
        int stalls0;
`ifdef FIFO_READ_STREAM_STATS_EN
        logic [31:0] sb0;
        logic [31:0] ss0;
`endif
        // T1: reset holds everything quiet even with data in the FIFO
        put(32'hA5A5_0001);
        repeat (3) drv_slot();
        @(negedge clk);
        check("t1_empty_low", {31'd0, p_read_empty}, 32'd0);
        check("t1_rd_en", {31'd0, p_read_en}, 32'd0);
        check("t1_valid", {31'd0, m_valid}, 32'd0);
        check("t1_data", m_data, 32'd0);
`ifdef FIFO_READ_STREAM_STATS_EN
        check("t1_stat_beats", stat_beats, 32'd0);
        check("t1_stat_stalls", stat_stalls, 32'd0);
`endif
        drv_slot();
        rst_n   = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        check("t1_no_early_rd", {31'd0, p_read_en}, 32'd0);
        // T2: single word, two cycles of latency, valid for one cycle
        @(negedge clk);
        check("t2_rd_cycle0", {31'd0, p_read_en}, 32'd1);
        @(negedge clk);
        check("t2_valid_cycle1", {31'd0, m_valid}, 32'd0);
        @(negedge clk);
        check("t2_valid_cycle2", {31'd0, m_valid}, 32'd1);
        check("t2_data", m_data, 32'hA5A5_0001);
        @(negedge clk);
        check("t2_valid_after", {31'd0, m_valid}, 32'd0);

        // T3: 64-word burst streams without gaps
        drv_slot();
        for (int i = 0; i < 64; i++) put(32'(i));
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!m_valid && waited < 20);
        run_len = 0;
        while (m_valid && run_len < 70) begin
            run_len++;
            @(negedge clk);
        end
        check("t3_run_len", 32'(run_len), 32'd64);
        check("t3_drained", 32'(exp_q.size()), 32'd0);

        // T4: back-pressure fills the buffer and stops requests
        drv_slot();
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) put(32'(i));
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (p_read_en) pulses++;
        end
        check("t4_rd_pulses", 32'(pulses), 32'd3);
        check("t4_valid", {31'd0, m_valid}, 32'd1);
        check("t4_data", m_data, 32'd0);
        drv_slot();
        m_ready = 1'b1;
        waited = 0;
        while (exp_q.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("t4_drained", 32'(exp_q.size()), 32'd0);

        // T5: random writes against random back-pressure
        @(negedge clk);
        beats0  = beats;
        stalls0 = stalls;
`ifdef FIFO_READ_STREAM_STATS_EN
        sb0 = stat_beats;
        ss0 = stat_stalls;
`endif
        fork
            begin
                for (int i = 0; i < 1000; ) begin
                    drv_slot();
                    if ($urandom_range(0, 2) != 0) begin
                        put($urandom);
                        i++;
                    end
                end
                wr_done = 1'b1;
            end
            begin
                int cyc;
                cyc = 0;
                while (!(wr_done && exp_q.size() == 0) && cyc < 20000) begin
                    drv_slot();
                    m_ready = 1'($urandom_range(0, 1));
                    cyc++;
                end
            end
        join
        @(negedge clk);
        check("t5_drained", 32'(exp_q.size()), 32'd0);
        check("t5_beats", 32'(beats - beats0), 32'd1000);
`ifdef FIFO_READ_STREAM_STATS_EN
        check("t5_stat_beats", stat_beats - sb0, 32'd1000);
        check("t5_stat_stalls", stat_stalls - ss0, 32'(stalls - stalls0));
`endif

        // T6: reset while two words are buffered and one is in flight
        drv_slot();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) put(32'hC000_0000 + 32'(i));
        repeat (5) @(negedge clk);
        check("t6_pre_valid", {31'd0, m_valid}, 32'd1);
        check("t6_pre_rd_off", {31'd0, p_read_en}, 32'd0);
        #2;
        rst_n = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        #1;
        check("t6_async_drop", {31'd0, m_valid}, 32'd0);
        check("t6_data_cleared", m_data, 32'd0);
        repeat (2) drv_slot();
        rst_n   = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) put(32'hB000_0000 + 32'(i));
        beats0 = beats;
        waited = 0;
        while (exp_q.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("t6_drained", 32'(exp_q.size()), 32'd0);
        check("t6_beats", 32'(beats - beats0), 32'd8);
        repeat (3) @(negedge clk);
        check("t6_idle", {31'd0, m_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
